// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined single-precision compare / min / max unit.
// S1 registers the accepted request, S2 registers the computed result.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid must keep its payload stable until
// the transfer, and ready never depends on the same-side valid.
module fcmp_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inv
);

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Maps a float to a key whose unsigned order matches numeric order;
    // both zeros share one key so +0 == -0.
    function automatic logic [31:0] order_key(input logic [31:0] v);
        if (v[30:0] == 31'd0) begin
            return 32'h8000_0000;
        end else if (!v[31]) begin
            return {1'b1, v[30:0]};
        end else begin
            return {1'b0, ~v[30:0]};
        end
    endfunction

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Stage S1: accepted request
    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [31:0]      s1_x1_q, s1_x1_d;
    logic [31:0]      s1_x2_q, s1_x2_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Stage S2: computed result
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_y_q, s2_y_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_inv_q, s2_inv_d;

    logic             advance;
    logic             accept;

    logic [31:0]      key1, key2;
    logic             nan1, nan2, snan1, snan2, any_nan, any_snan;
    logic             zero1, zero2;
    logic             k_eq, k_lt;
    logic [31:0]      res_y;
    logic             res_inv;

    assign advance  = ~s2_valid_q | out_ready;
    assign in_ready = rstn & (~s1_valid_q | advance);
    assign accept   = in_valid & in_ready;

    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_tag   = s2_tag_q;
    assign out_inv   = s2_inv_q;

    assign key1     = order_key(s1_x1_q);
    assign key2     = order_key(s1_x2_q);
    assign nan1     = is_nan(s1_x1_q);
    assign nan2     = is_nan(s1_x2_q);
    assign snan1    = nan1 & ~s1_x1_q[22];
    assign snan2    = nan2 & ~s1_x2_q[22];
    assign any_nan  = nan1 | nan2;
    assign any_snan = snan1 | snan2;
    assign zero1    = (s1_x1_q[30:0] == 31'd0);
    assign zero2    = (s1_x2_q[30:0] == 31'd0);
    assign k_eq     = (key1 == key2);
    assign k_lt     = (key1 < key2);

    // Result computation from the request held in S1.
    always_comb begin
        res_y   = 32'd0;
        res_inv = any_snan;
        case (s1_op_q)
            OP_FEQ: begin
                res_y = {31'd0, ~any_nan & k_eq};
            end
            OP_FLT: begin
                res_y   = {31'd0, ~any_nan & k_lt};
                res_inv = any_nan;
            end
            OP_FLE: begin
                res_y   = {31'd0, ~any_nan & (k_lt | k_eq)};
                res_inv = any_nan;
            end
            OP_FMIN: begin
                if (nan1 && nan2) begin
                    res_y = CANON_NAN;
                end else if (nan1) begin
                    res_y = s1_x2_q;
                end else if (nan2) begin
                    res_y = s1_x1_q;
                end else if (zero1 && zero2) begin
                    // -0 wins when either operand is -0
                    res_y = {s1_x1_q[31] | s1_x2_q[31], 31'd0};
                end else if (k_lt || k_eq) begin
                    res_y = s1_x1_q;
                end else begin
                    res_y = s1_x2_q;
                end
            end
            OP_FMAX: begin
                if (nan1 && nan2) begin
                    res_y = CANON_NAN;
                end else if (nan1) begin
                    res_y = s1_x2_q;
                end else if (nan2) begin
                    res_y = s1_x1_q;
                end else if (zero1 && zero2) begin
                    // +0 wins when either operand is +0
                    res_y = {s1_x1_q[31] & s1_x2_q[31], 31'd0};
                end else if (!k_lt) begin
                    res_y = s1_x1_q;
                end else begin
                    res_y = s1_x2_q;
                end
            end
            default: begin
                res_y   = 32'd0;
                res_inv = 1'b1;
            end
        endcase
    end

    // Next-state for both stages: S1 drains into S2 on advance, refills on accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_x1_d    = s1_x1_q;
        s1_x2_d    = s1_x2_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_tag_d   = s2_tag_q;
        s2_inv_d   = s2_inv_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_y_d   = res_y;
                s2_tag_d = s1_tag_q;
                s2_inv_d = res_inv;
            end
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_x1_d    = in_x1;
            s1_x2_d    = in_x2;
            s1_tag_d   = in_tag;
        end
    end

    // Pipeline registers; reset empties both stages and clears the outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'd0;
            s1_x1_q    <= 32'd0;
            s1_x2_q    <= 32'd0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= 32'd0;
            s2_tag_q   <= '0;
            s2_inv_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_x1_q    <= s1_x1_d;
            s1_x2_q    <= s1_x2_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_tag_q   <= s2_tag_d;
            s2_inv_q   <= s2_inv_d;
        end
    end

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed and randomized bench for fcmp_pipe with a
// sign/magnitude reference model and an in-order expected-result queue.
module tb_fcmp_pipe;

    localparam int TAG_W = 4;
    localparam int W     = 32 + TAG_W + 1;

    // clock / reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op     = 3'd0;
    logic [31:0]      in_x1     = 32'd0;
    logic [31:0]      in_x2     = 32'd0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_inv;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_inv   (out_inv)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    logic         last_acc     = 1'b0;
    logic         hold_pending = 1'b0;
    logic [W-1:0] hold_val     = '0;
    logic         lat_check    = 1'b0;
    logic         lit_en       = 1'b0;
    logic [31:0]  lit_y        = 32'd0;
    logic         lit_inv      = 1'b0;
    logic [31:0]  sa[5];
    logic [31:0]  sb[5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Numeric comparison of two non-NaN floats: -1, 0, +1.
    function automatic int fcmp(input logic [31:0] a, input logic [31:0] b);
        logic mag_lt;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 0;
        if (a[31] != b[31]) return a[31] ? -1 : 1;
        if (a[30:0] == b[30:0]) return 0;
        mag_lt = a[30:0] < b[30:0];
        if (!a[31]) return mag_lt ? -1 : 1;
        return mag_lt ? 1 : -1;
    endfunction

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [TAG_W-1:0] t);
        logic na, nb, sig, inv;
        logic [31:0] y;
        int c;
        na  = is_nan(a);
        nb  = is_nan(b);
        sig = (na && !a[22]) || (nb && !b[22]);
        c   = (na || nb) ? 0 : fcmp(a, b);
        y   = 32'd0;
        inv = sig;
        case (op)
            3'd0: y = {31'd0, !(na || nb) && c == 0};
            3'd1: begin y = {31'd0, !(na || nb) && c < 0};  inv = sig || na || nb; end
            3'd2: begin y = {31'd0, !(na || nb) && c <= 0}; inv = sig || na || nb; end
            3'd3: begin
                if (na && nb) y = 32'h7FC0_0000;
                else if (na) y = b;
                else if (nb) y = a;
                else if (a[30:0] == 31'd0 && b[30:0] == 31'd0) y = {a[31] | b[31], 31'd0};
                else y = (c <= 0) ? a : b;
            end
            3'd4: begin
                if (na && nb) y = 32'h7FC0_0000;
                else if (na) y = b;
                else if (nb) y = a;
                else if (a[30:0] == 31'd0 && b[30:0] == 31'd0) y = {a[31] & b[31], 31'd0};
                else y = (c >= 0) ? a : b;
            end
            default: begin y = 32'd0; inv = 1'b1; end
        endcase
        return {y, t, inv};
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 23'd0};
            2: return {s, 8'hFF, 1'b1, 22'($urandom)};
            3: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 4194303))};
            4: return other;
            5: return {s, 8'h00, 23'($urandom)};
            6: return {other[31:1], ~other[0]};
            default: return $urandom;
        endcase
    endfunction

    // driver: one clock cycle; drive at negedge, sample 1ns later, before the rising edge
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t, input logic ordy);
        logic [W-1:0] e;
        int ac;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_x1     = a;
        in_x2     = b;
        in_tag    = t;
        out_ready = ordy;
        #1;
        if (hold_pending) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({out_y, out_tag, out_inv}), 64'(hold_val));
        end
        if (out_valid && out_ready) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                check("result", 64'({out_y, out_tag, out_inv}), 64'(e));
                if (lat_check) check("latency", 64'(cyc - ac), 64'd2);
            end
        end
        hold_pending = out_valid && !out_ready;
        hold_val     = {out_y, out_tag, out_inv};
        last_acc     = v && in_ready;
        if (last_acc) begin
            if (lit_en) exp_q.push_back({lit_y, t, lit_inv});
            else        exp_q.push_back(model(op, a, b, t));
            acc_q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic send_lit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input logic [31:0] y, input logic inv);
        lit_en  = 1'b1;
        lit_y   = y;
        lit_inv = inv;
        step(1'b1, op, a, b, t, 1'b1);
        check("directed_accept", 64'(last_acc), 64'd1);
        lit_en  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b1);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int idx;
        int n;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        // reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_inv", 64'(out_inv), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // directed values with fixed 2-cycle latency
        lat_check = 1'b1;
        send_lit(3'd0, 32'h0000_0000, 32'h8000_0000, 4'd1, 32'd1, 1'b0);
        drain();
        send_lit(3'd1, 32'hBF80_0000, 32'h3F80_0000, 4'd2, 32'd1, 1'b0);
        send_lit(3'd2, 32'h7FC0_0000, 32'h0000_0000, 4'd3, 32'd0, 1'b1);
        send_lit(3'd3, 32'h7F80_0001, 32'h4000_0000, 4'd4, 32'h4000_0000, 1'b1);
        send_lit(3'd4, 32'h7FC0_0000, 32'h7FC0_0000, 4'd5, 32'h7FC0_0000, 1'b0);
        send_lit(3'd3, 32'h0000_0000, 32'h8000_0000, 4'd6, 32'h8000_0000, 1'b0);
        send_lit(3'd4, 32'h8000_0000, 32'h0000_0000, 4'd7, 32'h0000_0000, 1'b0);
        send_lit(3'd4, 32'h3F80_0000, 32'hBF80_0000, 4'd8, 32'h3F80_0000, 1'b0);
        send_lit(3'd6, 32'h3F80_0000, 32'h3F80_0000, 4'd9, 32'h0000_0000, 1'b1);
        send_lit(3'd1, 32'hC000_0000, 32'hBF80_0000, 4'd10, 32'd1, 1'b0);
        drain();

        // four back-to-back requests, tags 0..3
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'(i), $urandom, $urandom, 4'(i), 1'b1);
            check("b2b_accept", 64'(last_acc), 64'd1);
        end
        drain();
        lat_check = 1'b0;

        // output stalled for 5 cycles while requests are offered
        for (int i = 0; i < 5; i++) begin
            sa[i] = rand_operand($urandom);
            sb[i] = rand_operand(sa[i]);
        end
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 3'(idx % 5), sa[idx], sb[idx], 4'(8 + idx), 1'b0);
            if (last_acc) idx++;
            if (c >= 2) check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        check("stall_accepted", 64'(idx), 64'd2);
        n = 0;
        while (idx < 5 && n < 20) begin
            step(1'b1, 3'(idx % 5), sa[idx], sb[idx], 4'(8 + idx), 1'b1);
            if (last_acc) idx++;
            n++;
        end
        check("stall_release", 64'(idx), 64'd5);
        drain();

        // reset with both stages full
        step(1'b1, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd1, 1'b0);
        check("fill_s1", 64'(last_acc), 64'd1);
        step(1'b1, 3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd2, 1'b0);
        check("fill_s2", 64'(last_acc), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_y", 64'(out_y), 64'd0);
        exp_q.delete();
        acc_q.delete();
        hold_pending = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b1);
            check("no_stale", 64'(out_valid), 64'd0);
        end

        // randomized traffic with random backpressure and idle gaps
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rand_operand($urandom);
            rb  = rand_operand(ra);
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'($urandom_range(0, 3) != 0));
            end
            n = 0;
            do begin
                step(1'b1, rop, ra, rb, 4'(i), 1'($urandom_range(0, 3) != 0));
                n++;
            end while (!last_acc && n < 50);
            check("rand_accept", 64'(last_acc), 64'd1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
